// File: rtl/dp_ram_burst_reader.sv
// Burst read master for one dual-port RAM port: streams len words from addr as valid/ready beats with last.
// Latency: command accept at edge k -> first beat valid after edge k+2; one word per cycle sustained.
// Backpressure: 2-entry skid buffer absorbs the 1-cycle RAM latency; reads stall while the buffer could overflow.
module dp_ram_burst_reader #(
  parameter int P_DATA_W         = 640,
  parameter int P_LOG2_RAM_DEPTH = 9,
  parameter int P_LEN_W          = P_LOG2_RAM_DEPTH + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic [P_LOG2_RAM_DEPTH-1:0] i_cmd_addr,
  input  logic [P_LEN_W-1:0]          i_cmd_len,
  output logic                        o_ram_wr,
  output logic [P_LOG2_RAM_DEPTH-1:0] o_ram_addr,
  output logic [P_DATA_W-1:0]         o_ram_wdata,
  input  logic [P_DATA_W-1:0]         i_ram_data,
  output logic                        o_data_valid,
  input  logic                        i_data_ready,
  output logic [P_DATA_W-1:0]         o_data,
  output logic                        o_data_last,
  output logic                        o_busy,
  output logic                        o_done
);
  localparam int AW = P_LOG2_RAM_DEPTH;
  localparam logic [AW-1:0]      ADDR_ONE = 1;
  localparam logic [P_LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [P_LEN_W-1:0] LEN_ONE  = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t               state;
  logic [P_LEN_W-1:0]   remaining;     // words still to be issued to the RAM
  logic                 zero_len;      // current command had len=0
  logic                 inflight;      // a read was issued last cycle; its word is on i_ram_data now
  logic                 inflight_last; // that in-flight word is the final word of the burst
  logic [1:0]           count;         // skid buffer occupancy (0..2)
  logic [P_DATA_W-1:0]  head_dat, tail_dat;
  logic                 head_last, tail_last;
  logic [2:0]           occ;
  logic                 pop, push, issue, slot_ok, cmd_fire, drained;

  assign o_ram_wr     = 1'b0;
  assign o_ram_wdata  = '0;
  assign o_cmd_ready  = (state == IDLE);
  assign o_busy       = (state != IDLE);
  assign o_data_valid = (count != 2'd0);
  assign o_data       = head_dat;
  assign o_data_last  = head_last;

  assign cmd_fire = i_cmd_valid & o_cmd_ready;
  assign pop      = o_data_valid & i_data_ready;
  assign push     = inflight;
  // Words held or on their way, minus the one leaving this cycle, must leave room for one more.
  assign occ      = {1'b0, count} + {2'b00, inflight};
  assign slot_ok  = (occ - {2'b00, pop}) < 3'd2;
  assign issue    = (state == READ) && (remaining != LEN_ZERO) && slot_ok;
  // Nothing in flight and the buffer empties at this edge: the burst completes now.
  assign drained  = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

  // Burst control FSM: address generation, issue tracking and done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      zero_len      <= 1'b0;
      o_ram_addr    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_ONE);
      if (issue) begin
        o_ram_addr <= o_ram_addr + ADDR_ONE;
        remaining  <= remaining - LEN_ONE;
      end
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            o_ram_addr <= i_cmd_addr;
            remaining  <= i_cmd_len;
            zero_len   <= (i_cmd_len == LEN_ZERO);
            state      <= (i_cmd_len == LEN_ZERO) ? DONE : READ;
          end
        end
        READ: begin
          if (issue && (remaining == LEN_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (drained) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          // A zero-length burst reports done on the way back to IDLE.
          o_done <= zero_len;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid buffer: head feeds the stream, tail catches the word arriving during a stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count     <= 2'd0;
      head_dat  <= '0;
      head_last <= 1'b0;
      tail_dat  <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_dat  <= i_ram_data;
            head_last <= inflight_last;
          end else begin
            tail_dat  <= i_ram_data;
            tail_last <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_dat  <= tail_dat;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_dat  <= i_ram_data;
            head_last <= inflight_last;
          end else begin
            head_dat  <= tail_dat;
            head_last <= tail_last;
            tail_dat  <= i_ram_data;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_ram_burst_reader.sv
// Bench for dp_ram_burst_reader: RAM model with mem[i]=i, directed bursts, scoreboard queue of expected beats.
// Stimulus pushes expected beats at command accept; a negedge monitor compares every presented beat.
// Ready is either held high or toggled 1,0,0 to exercise stalls.
module tb_dp_ram_burst_reader;
  localparam int DW = 640;
  localparam int AW = 9;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_data = '0;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data;
  logic          data_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dp_ram_burst_reader #(.P_DATA_W(DW), .P_LOG2_RAM_DEPTH(AW), .P_LEN_W(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .o_ram_wr(ram_wr), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_data(ram_data),
    .o_data_valid(data_valid), .i_data_ready(data_ready), .o_data(data), .o_data_last(data_last),
    .o_busy(busy), .o_done(done)
  );

  // RAM model: address sampled at the edge, data valid the following cycle
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
  always @(posedge clk) ram_data <= mem[ram_addr];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, beats = 0, dones = 0, done_cyc = -1, busy_cnt = 0;
  int first_beat = -1, last_beat = -1;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: beats handshaking at the next edge are compared against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ram_wr !== 1'b0 || ram_wdata !== '0) begin
        errors++;
        $display("FAIL ram_write_idle actual=%0b/%0h required=0/0", ram_wr, ram_wdata[31:0]);
      end
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (data_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", data[31:0]);
        end else begin
          if (data !== exp_q[0].d || data_last !== exp_q[0].last) begin
            errors++;
            $display("FAIL beat actual=%0h/last%0b required=%0h/last%0b",
                     data[31:0], data_last, exp_q[0].d[31:0], exp_q[0].last);
          end
          if (data_ready) begin
            void'(exp_q.pop_front());
            beats++;
            if (first_beat < 0) first_beat = cyc + 1;
            last_beat = cyc + 1;
          end
        end
      end
    end
  end

  // Downstream ready: held high, or toggled 1,0,0,1,...
  initial begin : rdy_drv
    int ph;
    ph = 0;
    data_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) begin
        data_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        data_ready = 1'b1;
      end
    end
  end

  // Called just after a rising edge; returns accept edge k
  task automatic send_cmd(input int addr, input int len, output int k);
    logic r;
    int   n, c;
    n = 0;
    r = 1'b0;
    c = 0;
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    while (!r && n < 50) begin
      @(negedge clk);
      r = cmd_ready;
      c = cyc;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    k = c + 1;
    chk("cmd_accept", r, 1);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d    = mem[(addr + i) % (1 << AW)];
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (dones < target && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, (dones >= target), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k, k1, b, d0, bc;
    // reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", (data != '0), 0);
    chk("rst_last", data_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic burst addr=5 len=4
    first_beat = -1;
    b = beats;
    send_cmd(5, 4, k);
    chk("t1_ram_addr_after_accept", ram_addr, 5);
    wait_done(1, 40, "t1_done_seen");
    chk("t1_first_beat_edge", first_beat, k + 3);
    chk("t1_last_beat_edge", last_beat, k + 6);
    chk("t1_done_after_last", done_cyc, k + 6);
    chk("t1_beats", beats - b, 4);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_ready_again", cmd_ready, 1);

    // wrap-around burst
    first_beat = -1;
    send_cmd((1 << AW) - 2, 4, k);
    wait_done(2, 40, "t2_done_seen");
    chk("t2_wrap_seamless", last_beat - first_beat, 3);
    chk("t2_queue_empty", exp_q.size(), 0);

    // backpressure burst with toggling ready
    rdy_mode = 1;
    b = beats;
    send_cmd(40, 16, k);
    wait_done(3, 200, "t3_done_seen");
    rdy_mode = 0;
    chk("t3_beats", beats - b, 16);
    chk("t3_queue_empty", exp_q.size(), 0);

    // zero-length burst followed back-to-back by another command
    @(posedge clk); #1;
    b = beats;
    d0 = dones;
    busy_cnt = 0;
    send_cmd(0, 0, k);
    send_cmd(20, 2, k1);
    bc = busy_cnt;
    chk("t4_busy_one_cycle", bc, 1);
    chk("t4_done_edge", done_cyc, k + 1);
    chk("t4_done_count", dones - d0, 1);
    chk("t4_no_beats", beats - b, 0);
    chk("t4_back_to_back_accept", k1, k + 2);
    wait_done(d0 + 2, 40, "t4b_done_seen");
    chk("t4b_queue_empty", exp_q.size(), 0);

    // reset mid-burst after 3 beats
    b = beats;
    send_cmd(100, 8, k);
    begin
      int n;
      n = 0;
      while (beats < b + 3 && n < 40) begin
        @(posedge clk);
        n++;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t5_beats_before_rst", beats - b, 3);
    chk("t5_rst_cmd_ready", cmd_ready, 1);
    chk("t5_rst_ram_addr", ram_addr, 0);
    chk("t5_rst_valid", data_valid, 0);
    chk("t5_rst_data", (data != '0), 0);
    chk("t5_rst_last", data_last, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    exp_q.delete();
    d0 = dones;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done_after_rst", dones, d0);
    b = beats;
    send_cmd(300, 3, k);
    wait_done(d0 + 1, 40, "t5_new_done_seen");
    chk("t5_new_beats", beats - b, 3);
    chk("t5_queue_empty", exp_q.size(), 0);

    // full-depth burst
    first_beat = -1;
    b = beats;
    d0 = dones;
    send_cmd(7, 1 << AW, k);
    wait_done(d0 + 1, 700, "t6_done_seen");
    chk("t6_beats", beats - b, 1 << AW);
    chk("t6_first_beat_edge", first_beat, k + 3);
    chk("t6_consecutive", last_beat - first_beat, (1 << AW) - 1);
    chk("t6_queue_empty", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram_burst_reader.md
# dp_ram_burst_reader

Read-side master for one port of the team's dual-port RAM. Accepts a burst command (start address, word count), drives the RAM port's address lines, and absorbs the RAM's fixed 1-cycle read latency in a 2-entry skid buffer. Delivers the words as a valid/ready stream with a last flag. It sits between a RAM port and downstream EDC decode/check logic, and sustains one word per cycle under full throughput.

## Interface
- P_DATA_W, 640, RAM word width
- P_LOG2_RAM_DEPTH, 9, RAM address width (AW); depth 2**AW
- P_LEN_W, P_LOG2_RAM_DEPTH+1, burst length width; max length 2**AW

- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_addr  in  AW  burst start address
- i_cmd_len  in  P_LEN_W  number of words (0 allowed)
- o_ram_wr  out  1  RAM write enable; constant 0
- o_ram_addr  out  AW  RAM read address
- o_ram_wdata  out  P_DATA_W  RAM write data; constant 0
- i_ram_data  in  P_DATA_W  RAM read data, valid the cycle after the address is sampled
- o_data_valid  out  1  stream beat valid
- i_data_ready  in  1  downstream accepts beat
- o_data  out  P_DATA_W  stream data
- o_data_last  out  1  final beat of the burst
- o_busy  out  1  burst in progress (state != IDLE)
- o_done  out  1  one-cycle pulse at burst completion

## Operation
- States:
  - IDLE: o_cmd_ready=1. Handshake latches addr and len. len=0 -> DONE; else -> READ.
  - READ: issue reads. After the final issue -> DRAIN.
  - DRAIN: wait until in-flight=0 and buffer empty -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Issue rule: a read issues in a cycle when words remain and (buffer count + in-flight − pop) < 2. Pop = o_data_valid & i_data_ready.
  - On issue: o_ram_addr advances to the next address at the edge; in-flight is set for one cycle.
  - The word returned on i_ram_data in the following cycle is pushed into the buffer at the next edge.
- o_ram_addr is held when not issuing. Stale reads are never captured.
- Address arithmetic is modulo 2**AW: 2**AW−1 wraps to 0.
- o_data/o_data_last come from the buffer head. Both stay stable while o_data_valid & !i_data_ready.
- o_data_last=1 only on the beat carrying word number len−1.
- Buffer never overflows. Push and pop in the same cycle leave the count unchanged.

## Timing
- Reset (async assert, sync-safe deassert):
  - State IDLE; buffer and in-flight cleared.
  - o_cmd_ready=1, o_ram_addr=0.
  - o_data_valid=0, o_data=0, o_data_last=0, o_busy=0, o_done=0.
- Reset mid-burst: buffered and in-flight words are discarded. No o_done and no further beats.
- Command accepted at edge k:
  - o_ram_addr=addr after edge k.
  - o_data_valid=1 after edge k+2.
- i_data_ready held 1: beats at edges k+3 … k+2+len. o_done is high for the cycle after the last-beat edge, then IDLE; o_cmd_ready=1 again the following cycle.
- len=0: o_busy=1 for one cycle; o_done high after edge k+1; no beats.
- Backpressure: at most 2 words buffered. Issue resumes in the same cycle a pop frees a slot. No bubble is inserted when ready returns.
- o_cmd_ready is 0 throughout READ/DRAIN/DONE. Commands offered then are held off, not dropped.

## Test plan
- Preload mem[i]=i. Command addr=5, len=4, ready=1 -> beats 5,6,7,8 on consecutive cycles starting edge k+3; last on beat 8; o_done one cycle later.
- addr=2**AW−2, len=4 -> beats mem[510], mem[511], mem[0], mem[1] (AW=9); wrap is seamless.
- len=16 with i_data_ready toggling 1,0,0,1,… -> all 16 words in order, none duplicated or lost. Data stable while stalled; in-flight+buffer never exceeds 2.
- len=0 -> no o_data_valid; o_done one cycle after acceptance; back-to-back command accepted next.
- len=8, assert i_rst_n=0 after 3 beats -> outputs go to reset values immediately. No o_done. A new command after release streams correctly from its own addr.
- Full-depth burst, len=2**AW, ready=1 -> 512 beats in 512 consecutive cycles; o_ram_wr and o_ram_wdata stay 0 throughout.
